evm_tally_arbiter: RTL

//  Shared vote-tally controller sitting behind NUM_BOOTHS ballot-unit FSMs.

---
 rtl/evm_tally_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/evm_tally_arbiter.sv
// Shared vote-tally controller: round-robin arbitration among booth requests,
// saturating per-party counters, and officer readout while the poll is closed.
// Optional feature: define EVM_TALLY_TOTAL_EN to add the total_votes output.
module evm_tally_arbiter #(
  parameter int unsigned NUM_BOOTHS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_BOOTHS-1:0]   vote_req,
  input  logic [2*NUM_BOOTHS-1:0] vote_party,
  output logic [NUM_BOOTHS-1:0]   vote_ack,
  input  logic                    poll_open,
  input  logic                    result_req,
  input  logic [1:0]              result_sel,
  output logic                    result_valid,
  output logic [CNT_W-1:0]        result_count,
  output logic                    sat_flag,
`ifdef EVM_TALLY_TOTAL_EN
  output logic                    busy,
  output logic [CNT_W+1:0]        total_votes
`else
  output logic                    busy
`endif
);

  localparam int unsigned IdxW = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;

  typedef enum logic [1:0] {StIdle, StArb, StUpd, StRead} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       gnt_q, gnt_d;
  logic [1:0]            party_q, party_d;
  logic [CNT_W-1:0]      cnt_q [4];
  logic [CNT_W-1:0]      cnt_d [4];
  logic [CNT_W-1:0]      res_cnt_q, res_cnt_d;
  logic                  res_valid_q, res_valid_d;
  logic                  sat_q, sat_d;
`ifdef EVM_TALLY_TOTAL_EN
  logic [CNT_W+1:0]      total_q, total_d;
`endif

  logic                  found;
  logic [IdxW-1:0]       win;
  logic [1:0]            win_party;

  // Round-robin scan starting just after the last granted booth.
  always_comb begin
    int unsigned sum;
    logic [IdxW-1:0] cand;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 1; k <= NUM_BOOTHS; k++) begin
      sum = 32'(ptr_q) + k;
      if (sum >= NUM_BOOTHS) sum = sum - NUM_BOOTHS;
      cand = sum[IdxW-1:0];
      if (!found && vote_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_party = vote_party[{win, 1'b0} +: 2];
  end

  // Next-state, counter update and readout capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    party_d     = party_q;
    cnt_d       = cnt_q;
    res_cnt_d   = res_cnt_q;
    res_valid_d = 1'b0;
    sat_d       = sat_q;
`ifdef EVM_TALLY_TOTAL_EN
    total_d     = total_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (poll_open && |vote_req) begin
          state_d = StArb;
        end else if (!poll_open && result_req) begin
          // Capture now so the value is presented together with the READ pulse.
          state_d     = StRead;
          res_cnt_d   = cnt_q[result_sel];
          res_valid_d = 1'b1;
        end
      end
      StArb: begin
        if (found) begin
          gnt_d   = win;
          party_d = win_party;
          state_d = StUpd;
        end else begin
          state_d = StIdle;
        end
      end
      StUpd: begin
        ptr_d   = gnt_q;
        state_d = StIdle;
        if (cnt_q[party_q] == '1) begin
          sat_d = 1'b1;
        end else begin
          cnt_d[party_q] = cnt_q[party_q] + CNT_W'(1);
        end
`ifdef EVM_TALLY_TOTAL_EN
        if (total_q != '1) total_d = total_q + (CNT_W+2)'(1);
`endif
      end
      StRead: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= IdxW'(NUM_BOOTHS - 1);
      gnt_q       <= '0;
      party_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      res_cnt_q   <= '0;
      res_valid_q <= 1'b0;
      sat_q       <= 1'b0;
`ifdef EVM_TALLY_TOTAL_EN
      total_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      party_q     <= party_d;
      cnt_q       <= cnt_d;
      res_cnt_q   <= res_cnt_d;
      res_valid_q <= res_valid_d;
      sat_q       <= sat_d;
`ifdef EVM_TALLY_TOTAL_EN
      total_q     <= total_d;
`endif
    end
  end

  // Outputs; pulses are suppressed in a reset cycle so a dropped grant is never acked.
  always_comb begin
    vote_ack = '0;
    if (state_q == StUpd && !reset) vote_ack[gnt_q] = 1'b1;
    result_valid = res_valid_q && !reset;
    result_count = res_cnt_q;
    sat_flag     = sat_q;
    busy         = (state_q != StIdle);
`ifdef EVM_TALLY_TOTAL_EN
    total_votes  = total_q;
`endif
  end

endmodule
